// File: rtl/register_load_cell.sv
// register_load_cell: one bit of the register, a D flip-flop with synchronous clear and a hold/load mux
module register_load_cell (
    input  logic clk,
    input  logic reset_async,
    input  logic carga,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk)
        q <= reset_async ? 1'b0 : (carga ? d : q);
endmodule

// File: rtl/register_parallel_load_4bit.sv
// register_parallel_load_4bit: WIDTH-bit parallel-load register built from one load cell per bit
module register_parallel_load_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_async,
    input  logic             carga,
    input  logic [WIDTH-1:0] In,
    output logic [WIDTH-1:0] An
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        register_load_cell u_cell (
            .clk(clk),
            .reset_async(reset_async),
            .carga(carga),
            .d(In[i]),
            .q(An[i])
        );
    end
endmodule

// File: tb/tb_register_parallel_load_4bit.sv
// tb_register_parallel_load_4bit: directed checks of reset, load, hold, priority and mid-cycle reset
module tb_register_parallel_load_4bit;
    logic       clk_tb = 1'b0;
    logic       reset_async = 1'b0;
    logic       carga = 1'b0;
    logic [3:0] In = 4'h0;
    logic [3:0] An;
    logic [3:0] exp_an;
    int         total = 0;
    int         bad = 0;
    logic [3:0] vec_d [20] = '{4'h0, 4'hF, 4'h3, 4'h8, 4'h1, 4'hE, 4'h6, 4'hB, 4'h0, 4'h7,
                               4'hF, 4'h2, 4'hD, 4'h4, 4'h9, 4'hC, 4'h5, 4'hA, 4'hF, 4'h0};
    logic       vec_c [20] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                               1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    register_parallel_load_4bit #(.WIDTH(4)) dut (
        .clk(clk_tb),
        .reset_async(reset_async),
        .carga(carga),
        .In(In),
        .An(An)
    );

    always #5 clk_tb = ~clk_tb;

    task automatic step(input logic r, input logic c, input logic [3:0] d);
        @(negedge clk_tb);
        reset_async = r;
        carga = c;
        In = d;
        @(posedge clk_tb);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] expected);
        total++;
        assert (An === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, An, expected);
        end
    endtask

    initial begin
        step(1'b1, 1'b1, 4'hF);
        check("reset_edge1", 4'h0);
        step(1'b1, 1'b1, 4'hF);
        check("reset_edge2", 4'h0);
        step(1'b0, 1'b0, 4'hF);
        check("reset_release_hold", 4'h0);

        step(1'b0, 1'b1, 4'hA);
        check("load_a", 4'hA);
        step(1'b0, 1'b1, 4'h5);
        check("load_5", 4'h5);

        step(1'b0, 1'b0, 4'h0);
        check("hold_in0", 4'h5);
        step(1'b0, 1'b0, 4'hF);
        check("hold_inf", 4'h5);
        step(1'b0, 1'b0, 4'h3);
        check("hold_in3", 4'h5);

        step(1'b0, 1'b1, 4'hC);
        check("load_c", 4'hC);
        step(1'b1, 1'b1, 4'h7);
        check("reset_beats_load", 4'h0);

        step(1'b0, 1'b1, 4'h9);
        check("load_9", 4'h9);
        @(negedge clk_tb);
        carga = 1'b0;
        reset_async = 1'b1;
        #1;
        check("reset_before_edge", 4'h9);
        @(posedge clk_tb);
        #1;
        check("reset_at_edge", 4'h0);

        step(1'b0, 1'b1, 4'h9);
        check("reload_9", 4'h9);
        carga = 1'b0;
        #2 reset_async = 1'b1;
        #2 reset_async = 1'b0;
        check("pulse_between_edges", 4'h9);
        @(posedge clk_tb);
        #1;
        check("after_pulse_edge", 4'h9);

        exp_an = 4'h9;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, vec_c[k], vec_d[k]);
            if (vec_c[k]) exp_an = vec_d[k];
            check($sformatf("vec%0d", k), exp_an);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
